// File: rtl/pipe_io_panel.sv
// pipe_io_panel
//   Board-side I/O responder for the pipelined CPU's memory-mapped ports.
//   Debounces 12 slide switches into two 6-bit input ports and scans a
//   6-digit, active-low, multiplexed seven-segment display that shows the
//   low bytes of the CPU's three output ports.
//
// Ports
//   clock      system clock, rising edge
//   reset      synchronous, active-high
//   sw_raw     asynchronous switch levels ([5:0] -> in_port0, [11:6] -> in_port1)
//   out_port0  CPU output port 0, bits [7:0] shown on digits 1..0
//   out_port1  CPU output port 1, bits [7:0] shown on digits 3..2
//   out_port2  CPU output port 2, bits [7:0] shown on digits 5..4
//   in_port0   debounced sw_raw[5:0]
//   in_port1   debounced sw_raw[11:6]
//   in_chg     one-cycle pulse in the cycle either input port changes
//   an         digit enables, active-low, one-hot
//   seg        segments {g,f,e,d,c,b,a}, active-low
module pipe_io_panel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_DIV        = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] sw_raw,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  input  logic [31:0] out_port2,
  output logic [5:0]  in_port0,
  output logic [5:0]  in_port1,
  output logic        in_chg,
  output logic [5:0]  an,
  output logic [6:0]  seg
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_MAX    = DW'(SCAN_DIV - 1);
  localparam logic [2:0]    LAST_DIGIT = 3'd5;

  // ---------------------------------------------------------------- input path
  logic [11:0]   r_s1;
  logic [11:0]   r_s2;
  logic [11:0]   r_stable;
  logic [CW-1:0] r_cnt [12];
  logic          r_chg;
  logic [11:0]   w_upd;

  // A bit is accepted when it has differed from the stable level for
  // DEBOUNCE_CYCLES consecutive edges, i.e. the counter is already saturated.
  always_comb begin
    w_upd = '0;
    for (int unsigned i = 0; i < 12; i++) begin
      w_upd[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_stable <= '0;
      r_chg    <= 1'b0;
      for (int unsigned i = 0; i < 12; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1  <= sw_raw;
      r_s2  <= r_s1;
      r_chg <= |w_upd;
      for (int unsigned i = 0; i < 12; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_upd[i]) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign in_port0 = r_stable[5:0];
  assign in_port1 = r_stable[11:6];
  assign in_chg   = r_chg;

  // -------------------------------------------------------------- display path
  logic [DW-1:0] r_div;
  logic [2:0]    r_digit;
  logic [23:0]   r_snap;
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          w_div_wrap;
  logic          w_frame_end;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg;
  logic          w_unused;

  assign w_div_wrap  = (r_div == DIV_MAX);
  assign w_frame_end = w_div_wrap && (r_digit == LAST_DIGIT);
  assign w_nib       = r_snap[{r_digit, 2'b00} +: 4];

  // Only the low byte of each output port is displayed.
  assign w_unused = ^{out_port0[31:8], out_port1[31:8], out_port2[31:8]};

  always_comb begin
    w_seg = '1;
    case (w_nib)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      4'hF: w_seg = 7'h0E;
      default: w_seg = '1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_div   <= '0;
      r_digit <= '0;
      r_snap  <= '0;
      r_an    <= '1;
      r_seg   <= '1;
    end else begin
      r_div <= w_div_wrap ? '0 : r_div + DW'(1);
      if (w_div_wrap) begin
        r_digit <= (r_digit == LAST_DIGIT) ? 3'd0 : r_digit + 3'd1;
      end
      // Snapshot only between frames so a frame never mixes old and new data.
      if (w_frame_end) begin
        r_snap <= {out_port2[7:0], out_port1[7:0], out_port0[7:0]};
      end
      r_an  <= ~(6'b000001 << r_digit);
      r_seg <= w_seg;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule
